// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: init hand-off, refresh priority, write/read round-robin,
// registered pin mux and a grant watchdog that reclaims a stuck bus.
module sdram_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 13,
  parameter int BANK_W    = 2,
  parameter int MAX_GRANT = 1024
) (
  input  logic              arb_clk,
  input  logic              arb_rst,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic [3:0]        aref_cmd,
  input  logic [BANK_W-1:0] aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              aref_end,
  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dq,
  input  logic              wr_dq_oe,
  input  logic              wr_end,
  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_end,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              aref_pending,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [BANK_W-1:0] sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe,
  output logic              arb_timeout_err
);

  localparam int CNT_W = $clog2(MAX_GRANT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_GRANT - 1);
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wd_cnt, wd_cnt_nxt;
  logic              last_wr, last_wr_nxt;
  logic              in_grant, grant_end, timeout_set;
  logic [3:0]        cmd_src;
  logic [BANK_W-1:0] ba_src;
  logic [ADDR_W-1:0] addr_src;
  logic [DATA_W-1:0] dq_src;
  logic              oe_src;

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      state           <= S_INIT;
      wd_cnt          <= '0;
      last_wr         <= 1'b0;
      arb_timeout_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      wd_cnt  <= wd_cnt_nxt;
      last_wr <= last_wr_nxt;
      if (timeout_set) arb_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_end   = 1'b0;
    timeout_set = 1'b0;
    in_grant    = (state == S_AREF) || (state == S_WRITE) || (state == S_READ);
    case (state)
      S_INIT:  if (init_end) state_nxt = S_ARBIT;
      S_ARBIT: begin
        if (aref_req)              state_nxt = S_AREF;
        else if (wr_req && rd_req) state_nxt = last_wr ? S_READ : S_WRITE;
        else if (wr_req)           state_nxt = S_WRITE;
        else if (rd_req)           state_nxt = S_READ;
      end
      S_AREF:  grant_end = aref_end;
      S_WRITE: grant_end = wr_end;
      S_READ:  grant_end = rd_end;
      default: state_nxt = S_INIT;
    endcase
    // A grant ends on its own done pulse, or the watchdog takes the bus back.
    if (in_grant) begin
      if (grant_end) begin
        state_nxt = S_ARBIT;
      end else if (wd_cnt == CNT_LAST) begin
        state_nxt   = S_ARBIT;
        timeout_set = 1'b1;
      end
    end
    wd_cnt_nxt  = (in_grant && state_nxt == state) ? wd_cnt + CNT_W'(1) : '0;
    last_wr_nxt = last_wr;
    if (state == S_WRITE && state_nxt != S_WRITE) last_wr_nxt = 1'b1;
    if (state == S_READ  && state_nxt != S_READ)  last_wr_nxt = 1'b0;
  end

  always_comb begin
    cmd_src  = CMD_NOP;
    ba_src   = '1;
    addr_src = '1;
    dq_src   = '0;
    oe_src   = 1'b0;
    case (state)
      S_INIT:  begin cmd_src = init_cmd; ba_src = init_bank; addr_src = init_addr; end
      S_AREF:  begin cmd_src = aref_cmd; ba_src = aref_bank; addr_src = aref_addr; end
      S_WRITE: begin
        cmd_src = wr_cmd; ba_src = wr_bank; addr_src = wr_addr;
        dq_src  = wr_dq;  oe_src = wr_dq_oe;
      end
      S_READ:  begin cmd_src = rd_cmd; ba_src = rd_bank; addr_src = rd_addr; end
      default: ;
    endcase
  end

  // Pin register stage: one cycle from source to SDRAM pins.
  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      sdram_cke    <= 1'b0;
      sdram_cmd    <= CMD_NOP;
      sdram_ba     <= '1;
      sdram_addr   <= '1;
      sdram_dq_out <= '0;
      sdram_dq_oe  <= 1'b0;
    end else begin
      sdram_cke    <= 1'b1;
      sdram_cmd    <= cmd_src;
      sdram_ba     <= ba_src;
      sdram_addr   <= addr_src;
      sdram_dq_out <= dq_src;
      sdram_dq_oe  <= oe_src;
    end
  end

  assign aref_en      = (state == S_AREF);
  assign wr_en        = (state == S_WRITE);
  assign rd_en        = (state == S_READ);
  assign aref_pending = aref_req && (state == S_WRITE || state == S_READ);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed vector table, hand-written corner sequences and
// a randomized run against a bus-ownership reference model.
module tb_sdram_arbiter;
  localparam int DATA_W = 16, ADDR_W = 13, BANK_W = 2, MAX_GRANT = 16;

  logic              arb_clk, arb_rst;
  logic [3:0]        init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [BANK_W-1:0] init_bank, aref_bank, wr_bank, rd_bank;
  logic [ADDR_W-1:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic              init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic [DATA_W-1:0] wr_dq;
  logic              wr_dq_oe;
  logic              aref_en, wr_en, rd_en, aref_pending, sdram_cke, sdram_dq_oe;
  logic [3:0]        sdram_cmd;
  logic [BANK_W-1:0] sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              arb_timeout_err;

  sdram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W), .MAX_GRANT(MAX_GRANT)) dut (
    .arb_clk(arb_clk), .arb_rst(arb_rst),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr), .init_end(init_end),
    .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_bank(aref_bank), .aref_addr(aref_addr),
    .aref_end(aref_end),
    .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_dq(wr_dq),
    .wr_dq_oe(wr_dq_oe), .wr_end(wr_end),
    .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_end(rd_end),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .aref_pending(aref_pending),
    .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .arb_timeout_err(arb_timeout_err)
  );

  initial arb_clk = 1'b0;
  always #5 arb_clk = ~arb_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge arb_clk);
    #1;
  endtask

  task automatic clear_inputs();
    init_cmd = 4'b0111; init_bank = '0; init_addr = '0; init_end = 1'b0;
    aref_req = 1'b0; aref_cmd = '0; aref_bank = '0; aref_addr = '0; aref_end = 1'b0;
    wr_req = 1'b0; wr_cmd = '0; wr_bank = '0; wr_addr = '0; wr_dq = '0; wr_dq_oe = 1'b0;
    wr_end = 1'b0;
    rd_req = 1'b0; rd_cmd = '0; rd_bank = '0; rd_addr = '0; rd_end = 1'b0;
  endtask

  // Reference model: who owns the bus (0 init, 1 idle, 2 refresh, 3 write, 4 read),
  // how many cycles the current owner has held it, and whose turn is next.
  int                m_owner, m_held;
  bit                m_last_wr, m_err, m_cke;
  logic [3:0]        m_cmd;
  logic [BANK_W-1:0] m_ba;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dq;
  logic              m_oe;

  task automatic model_reset();
    m_owner = 0; m_held = 0; m_last_wr = 0; m_err = 0; m_cke = 0;
    m_cmd = 4'b0111; m_ba = '1; m_addr = '1; m_dq = '0; m_oe = 1'b0;
  endtask

  task automatic model_edge();
    bit done;
    m_cke = 1;
    m_cmd = 4'b0111; m_ba = '1; m_addr = '1; m_dq = '0; m_oe = 1'b0;
    case (m_owner)
      0: begin m_cmd = init_cmd; m_ba = init_bank; m_addr = init_addr; end
      2: begin m_cmd = aref_cmd; m_ba = aref_bank; m_addr = aref_addr; end
      3: begin m_cmd = wr_cmd; m_ba = wr_bank; m_addr = wr_addr; m_dq = wr_dq; m_oe = wr_dq_oe; end
      4: begin m_cmd = rd_cmd; m_ba = rd_bank; m_addr = rd_addr; end
      default: ;
    endcase
    if (m_owner == 0) begin
      if (init_end) m_owner = 1;
    end else if (m_owner == 1) begin
      if (aref_req) m_owner = 2;
      else if (wr_req && rd_req) m_owner = m_last_wr ? 4 : 3;
      else if (wr_req) m_owner = 3;
      else if (rd_req) m_owner = 4;
      m_held = 1;
    end else begin
      done = (m_owner == 2 && aref_end) || (m_owner == 3 && wr_end) || (m_owner == 4 && rd_end);
      if (done || m_held == MAX_GRANT) begin
        if (!done) m_err = 1;
        if (m_owner == 3) m_last_wr = 1;
        if (m_owner == 4) m_last_wr = 0;
        m_owner = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  typedef struct packed {
    logic a, w, r, ae, we, re;   // aref_req wr_req rd_req aref_end wr_end rd_end
    logic ea, ew, er, ep;        // expected aref_en wr_en rd_en aref_pending
  } vec_t;
  vec_t tv[15];

  initial begin
    int n;
    tv[0]  = 10'b111000_1000; tv[1]  = 10'b111100_0000; tv[2]  = 10'b011000_0100;
    tv[3]  = 10'b111000_0101; tv[4]  = 10'b111010_0000; tv[5]  = 10'b111000_1000;
    tv[6]  = 10'b011100_0000; tv[7]  = 10'b011000_0010; tv[8]  = 10'b011010_0010;
    tv[9]  = 10'b011001_0000; tv[10] = 10'b011000_0100; tv[11] = 10'b001010_0000;
    tv[12] = 10'b001000_0010; tv[13] = 10'b001001_0000; tv[14] = 10'b000000_0000;

    clear_inputs();
    arb_rst = 1'b1;
    #12;
    chk("rst_cmd", sdram_cmd, 4'b0111);
    chk("rst_ba", sdram_ba, 2'b11);
    chk("rst_addr", sdram_addr, 13'h1fff);
    chk("rst_dq", sdram_dq_out, 0);
    chk("rst_oe", sdram_dq_oe, 0);
    chk("rst_cke", sdram_cke, 0);
    chk("rst_grants", {aref_en, wr_en, rd_en, aref_pending}, 0);
    chk("rst_err", arb_timeout_err, 0);
    tick();
    arb_rst = 1'b0;
    tick();
    chk("cke_up", sdram_cke, 1);

    init_cmd = 4'b0010; init_bank = 2'b01; init_addr = 13'h0123;
    tick();
    chk("init_cmd", sdram_cmd, 4'b0010);
    chk("init_ba", sdram_ba, 2'b01);
    chk("init_addr", sdram_addr, 13'h0123);
    init_end = 1'b1;
    tick();
    chk("init_last_cmd", sdram_cmd, 4'b0010);
    tick();
    chk("arbit_nop", sdram_cmd, 4'b0111);
    chk("arbit_addr", sdram_addr, 13'h1fff);
    chk("arbit_idle", {aref_en, wr_en, rd_en}, 0);

    for (int i = 0; i < 15; i++) begin
      {aref_req, wr_req, rd_req, aref_end, wr_end, rd_end} = {tv[i].a, tv[i].w, tv[i].r,
                                                              tv[i].ae, tv[i].we, tv[i].re};
      tick();
      chk($sformatf("vec%0d", i), {aref_en, wr_en, rd_en, aref_pending},
          {tv[i].ea, tv[i].ew, tv[i].er, tv[i].ep});
    end
    {aref_req, wr_req, rd_req, aref_end, wr_end, rd_end} = '0;

    // Watchdog: read never finishes; a write waits behind it.
    rd_req = 1'b1;
    tick();
    chk("wd_rd_grant", rd_en, 1);
    chk("wd_err_clear", arb_timeout_err, 0);
    rd_req = 1'b0; wr_req = 1'b1;
    n = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!rd_en) break;
      n++;
    end
    chk("wd_cycles", n, MAX_GRANT);
    chk("wd_err_set", arb_timeout_err, 1);
    tick();
    chk("wd_next_wr", wr_en, 1);
    chk("wd_err_sticky", arb_timeout_err, 1);

    // Reset in the middle of a write with the data bus driven.
    wr_dq_oe = 1'b1; wr_dq = 16'hbeef; wr_cmd = 4'b0100;
    tick();
    chk("wr_oe", sdram_dq_oe, 1);
    chk("wr_dq", sdram_dq_out, 16'hbeef);
    chk("wr_cmd", sdram_cmd, 4'b0100);
    #2 arb_rst = 1'b1;
    #1;
    chk("arst_oe", sdram_dq_oe, 0);
    chk("arst_cmd", sdram_cmd, 4'b0111);
    chk("arst_cke", sdram_cke, 0);
    chk("arst_grant", wr_en, 0);
    chk("arst_err", arb_timeout_err, 0);
    tick();
    arb_rst = 1'b0;
    clear_inputs();
    wr_req = 1'b1;
    init_cmd = 4'b0001;
    tick();
    chk("post_rst_init", {sdram_cmd, wr_en}, {4'b0001, 1'b0});

    // Randomized run against the ownership model.
    clear_inputs();
    arb_rst = 1'b1;
    #3 arb_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 800; i++) begin
      init_end  = (i >= 4);
      aref_req  = ($urandom_range(0, 5) == 0);
      wr_req    = $urandom_range(0, 1) != 0;
      rd_req    = $urandom_range(0, 1) != 0;
      aref_end  = ($urandom_range(0, 6) == 0);
      wr_end    = ($urandom_range(0, 9) == 0);
      rd_end    = ($urandom_range(0, 12) == 0);
      init_cmd  = 4'($urandom); init_bank = 2'($urandom); init_addr = 13'($urandom);
      aref_cmd  = 4'($urandom); aref_bank = 2'($urandom); aref_addr = 13'($urandom);
      wr_cmd    = 4'($urandom); wr_bank   = 2'($urandom); wr_addr   = 13'($urandom);
      rd_cmd    = 4'($urandom); rd_bank   = 2'($urandom); rd_addr   = 13'($urandom);
      wr_dq     = 16'($urandom); wr_dq_oe = $urandom_range(0, 1) != 0;
      @(posedge arb_clk);
      model_edge();
      #1;
      chk($sformatf("rnd%0d_grants", i), {aref_en, wr_en, rd_en},
          {m_owner == 2, m_owner == 3, m_owner == 4});
      chk($sformatf("rnd%0d_pend", i), aref_pending,
          aref_req && (m_owner == 3 || m_owner == 4));
      chk($sformatf("rnd%0d_pins", i), {sdram_cke, sdram_cmd, sdram_ba, sdram_addr},
          {m_cke, m_cmd, m_ba, m_addr});
      chk($sformatf("rnd%0d_dq", i), {sdram_dq_oe, sdram_dq_out}, {m_oe, m_dq});
      chk($sformatf("rnd%0d_err", i), arb_timeout_err, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
